fill_seal_line: RTL and testbench
=================================

# fill_seal_line

Parametrised filling/sealing line controller: N_LANES independent Moore filler lanes share a single Mealy sealer through a round-robin arbiter. It adds timed fill and seal phases, bounded re-seal retries on a failed quality check, reject signalling and saturating production counters. It sits at the top of the packaging datapath and supersedes the single-lane filler/sealer pair.

## Interface
- N_LANES, 2: number of filler lanes, legal 1..8
- FILL_CYCLES, 8: cycles `llenando[i]` is held per fill, ≥1
- SEAL_CYCLES, 4: cycles `sellando` is held per seal attempt, ≥1
- MAX_RETRY, 2: re-seal attempts after a failed check, 0..7
- CNT_W, 8: width of the production counters
- LW (localparam): `$clog2(N_LANES)`, minimum 1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- startfill  in  N_LANES  per-lane fill request, level-sampled
- productook  in  1  quality verdict, sampled only in S_CHECK
- llenando  out  N_LANES  lane i is filling
- sellando  out  1  sealer is sealing
- seal_lane  out  LW  lane currently owned by the sealer, 0 when idle
- LED  out  1  Mealy good-product pulse
- reject  out  1  Mealy reject pulse
- good_count  out  CNT_W  accepted products, saturating
- reject_count  out  CNT_W  rejected products, saturating
- state_filler  out  3*N_LANES  lane i state code in bits [3i+2:3i]
- state_sealer  out  3  sealer state code

## Operation
- **Lane FSM (Moore)** has four states:
  - L_IDLE=0: go to L_FILL when `startfill[i]` is 1; load the fill counter with FILL_CYCLES-1.
  - L_FILL=1: `llenando[i]`=1; decrement the counter; go to L_FULL when it reaches 0.
  - L_FULL=2: wait for a sealer grant, then go to L_SEAL.
  - L_SEAL=3: wait for release from the sealer, then go to L_IDLE.
  - `startfill` is ignored in every state except L_IDLE.
- **Sealer FSM** has three states:
  - S_IDLE=0: if any lane is in L_FULL, grant the first one in round-robin order starting at `rr_ptr`. Set `rr_ptr` to grant+1 (mod N_LANES), load the seal counter with SEAL_CYCLES-1, clear `retry`, and go to S_SEAL.
  - S_SEAL=1: `sellando`=1; count down; go to S_CHECK at 0.
  - S_CHECK=2 lasts exactly one cycle. It resolves as follows:
    - `productook`=1: LED=1 (combinational), increment `good_count`, release the lane, go to S_IDLE.
    - `productook`=0 and `retry`<MAX_RETRY: increment `retry`, reload the seal counter, go to S_SEAL. No pulse.
    - `productook`=0 and `retry`==MAX_RETRY: reject=1 (combinational), increment `reject_count`, release the lane, go to S_IDLE.
- Counters saturate at 2^CNT_W−1 and never wrap.
- `seal_lane` is registered at grant time and holds through S_CHECK. It is 0 in S_IDLE.
- **Reset (rst=0, asynchronous):** all lanes go to L_IDLE, the sealer to S_IDLE, and `rr_ptr`, `retry`, both timers and both counters to 0. Every output is 0. Assertion mid-fill or mid-seal aborts immediately without counting anything.

## Timing
- `startfill[i]` sampled high at edge t:
  - `llenando[i]` is high for cycles t+1 … t+FILL_CYCLES.
  - The lane is in L_FULL during cycle t+FILL_CYCLES+1.
- With the sealer idle, the grant happens at the end of that cycle:
  - `sellando` is high for SEAL_CYCLES cycles, from t+FILL_CYCLES+2.
  - S_CHECK follows in the next cycle.
  - The lane is in L_IDLE one cycle after a passing S_CHECK.
- Each failed check adds SEAL_CYCLES+1 cycles. LED and reject are never high together and each lasts exactly one cycle.
- Simultaneous L_FULL lanes are granted one at a time in round-robin order. No lane waits more than N_LANES−1 seal jobs.
- A lane released at edge e can accept `startfill` sampled at edge e+1 at the earliest. A request at edge e itself is ignored.
- A lane reaching L_FULL in the same cycle the sealer returns to S_IDLE is granted at the following edge.

## Structure
- Package `fill_seal_pkg` holds:
  - lane state codes L_* and sealer codes S_*, as localparam/enum with 3-bit encoding;
  - the shared counter-saturation function.
- Sub-module `fill_lane` holds one lane FSM plus its fill counter. It has ports `grant` and `release`, and outputs `full`, `llenando` and `state`. It is instantiated N_LANES times in a generate loop.
- The sealer FSM, round-robin arbiter and counters live in the top module.

## Test plan
- N=2, F=8, S=4. Single pulse on `startfill[0]` at edge 0:
  - `llenando[0]` is high for cycles 1–8;
  - `sellando` is high for cycles 10–13;
  - `productook`=1 in cycle 14 gives LED=1 in cycle 14 only;
  - `good_count`=1 and lane 0 is back in L_IDLE at cycle 15.
- `startfill`=2'b11 at the same edge:
  - lane 0 is sealed first, then lane 1;
  - a second simultaneous round starts with lane 0 again (`rr_ptr` wrap at N=2);
  - `good_count`=4.
- MAX_RETRY=2 with `productook` held 0:
  - three seal bursts of 4 cycles each, separated by S_CHECK cycles;
  - `reject` pulses once and `reject_count`=1;
  - `good_count` is unchanged and the lane returns to L_IDLE.
- Fail once, then pass:
  - two seal bursts, LED pulse, `good_count`+1;
  - `retry` is cleared at the next grant.
- CNT_W=2 with 5 good products: `good_count` sticks at 3.
- Assert rst low mid-seal (cycle 11 of the first test):
  - every output is 0 asynchronously, before the next edge;
  - after release, all states are 0 and no counter has changed.

Source files
------------

// File: rtl/fill_seal_pkg.sv
// Shared types and helpers for the fill/seal line.
// Holds the lane and sealer state codes plus the saturating increment.
package fill_seal_pkg;

    typedef enum logic [2:0] {
        L_IDLE = 3'd0,
        L_FILL = 3'd1,
        L_FULL = 3'd2,
        L_SEAL = 3'd3
    } lane_state_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEAL  = 3'd1,
        S_CHECK = 3'd2
    } seal_state_e;

    // Increment v, holding at maxv instead of wrapping.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input logic [31:0] maxv
    );
        return (v >= maxv) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fill_lane.sv
// One Moore filler lane: idle -> fill (timed) -> full -> seal -> idle.
// Ports: clk_i, rst_ni, start_i, grant_i, release_i / full_o, llenando_o, state_o.
module fill_lane
    import fill_seal_pkg::*;
#(
    parameter int FILL_CYCLES = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       grant_i,
    input  logic       release_i,
    output logic       full_o,
    output logic       llenando_o,
    output logic [2:0] state_o
);

    localparam int FW = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;

    lane_state_e   state_q;
    logic [FW-1:0] cnt_q;
    logic          fill_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= L_IDLE;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
        end else begin
            unique case (state_q)
                L_IDLE: begin
                    if (start_i) begin
                        state_q <= L_FILL;
                        cnt_q   <= FW'(FILL_CYCLES - 1);
                        fill_q  <= 1'b1;
                    end
                end
                L_FILL: begin
                    if (cnt_q == '0) begin
                        state_q <= L_FULL;
                        fill_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - FW'(1);
                    end
                end
                L_FULL: begin
                    if (grant_i) state_q <= L_SEAL;
                end
                L_SEAL: begin
                    if (release_i) state_q <= L_IDLE;
                end
                default: begin
                    state_q <= L_IDLE;
                    fill_q  <= 1'b0;
                end
            endcase
        end
    end

    assign full_o     = (state_q == L_FULL);
    assign llenando_o = fill_q;
    assign state_o    = state_q;

endmodule

// File: rtl/fill_seal_line.sv
// N filler lanes sharing one Mealy sealer via a round-robin arbiter,
// with timed seal, bounded re-seal retries and saturating counters.
// Inputs: clk, rst (async, active-low), startfill[N], productook.
// Outputs: llenando[N], sellando, seal_lane, LED, reject, good_count,
//          reject_count, state_filler[3N], state_sealer.
module fill_seal_line
    import fill_seal_pkg::*;
#(
    parameter int N_LANES     = 2,
    parameter int FILL_CYCLES = 8,
    parameter int SEAL_CYCLES = 4,
    parameter int MAX_RETRY   = 2,
    parameter int CNT_W       = 8,
    localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_LANES-1:0]   startfill,
    input  logic                 productook,
    output logic [N_LANES-1:0]   llenando,
    output logic                 sellando,
    output logic [LW-1:0]        seal_lane,
    output logic                 LED,
    output logic                 reject,
    output logic [CNT_W-1:0]     good_count,
    output logic [CNT_W-1:0]     reject_count,
    output logic [3*N_LANES-1:0] state_filler,
    output logic [2:0]           state_sealer
);

    localparam int SW = (SEAL_CYCLES > 1) ? $clog2(SEAL_CYCLES) : 1;
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    seal_state_e      sstate_q;
    logic [SW-1:0]    scnt_q;
    logic [2:0]       retry_q;
    logic [LW-1:0]    rr_q;
    logic [LW-1:0]    lane_q;
    logic             sellando_q;
    logic [CNT_W-1:0] good_q;
    logic [CNT_W-1:0] rej_q;

    logic [N_LANES-1:0] full;
    logic [N_LANES-1:0] grant;
    logic [N_LANES-1:0] rel;

    logic          any_full;
    logic [LW-1:0] gnt_idx;
    logic [LW-1:0] rr_d;
    logic          gnt_fire;
    logic          chk;
    logic          last_try;
    logic          rel_fire;
    logic [CNT_W-1:0] good_d;
    logic [CNT_W-1:0] rej_d;
    int            idx;

    // First full lane at or after rr_q, wrapping around.
    always_comb begin
        any_full = 1'b0;
        gnt_idx  = '0;
        idx      = 0;
        for (int k = 0; k < N_LANES; k++) begin
            idx = (int'(rr_q) + k) % N_LANES;
            if (!any_full && full[LW'(idx)]) begin
                any_full = 1'b1;
                gnt_idx  = LW'(idx);
            end
        end
    end

    assign rr_d     = (gnt_idx == LW'(N_LANES - 1)) ? '0 : gnt_idx + LW'(1);
    assign gnt_fire = (sstate_q == S_IDLE) && any_full;
    assign chk      = (sstate_q == S_CHECK);
    assign last_try = (retry_q == 3'(MAX_RETRY));
    assign rel_fire = chk && (productook || last_try);
    assign good_d   = CNT_W'(sat_inc(32'(good_q), CNT_MAX));
    assign rej_d    = CNT_W'(sat_inc(32'(rej_q), CNT_MAX));

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        assign grant[i] = gnt_fire && (gnt_idx == LW'(i));
        assign rel[i]   = rel_fire && (lane_q == LW'(i));

        fill_lane #(
            .FILL_CYCLES(FILL_CYCLES)
        ) u_lane (
            .clk_i     (clk),
            .rst_ni    (rst),
            .start_i   (startfill[i]),
            .grant_i   (grant[i]),
            .release_i (rel[i]),
            .full_o    (full[i]),
            .llenando_o(llenando[i]),
            .state_o   (state_filler[3*i +: 3])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sstate_q   <= S_IDLE;
            scnt_q     <= '0;
            retry_q    <= '0;
            rr_q       <= '0;
            lane_q     <= '0;
            sellando_q <= 1'b0;
            good_q     <= '0;
            rej_q      <= '0;
        end else begin
            unique case (sstate_q)
                S_IDLE: begin
                    if (any_full) begin
                        sstate_q   <= S_SEAL;
                        lane_q     <= gnt_idx;
                        rr_q       <= rr_d;
                        scnt_q     <= SW'(SEAL_CYCLES - 1);
                        retry_q    <= '0;
                        sellando_q <= 1'b1;
                    end
                end
                S_SEAL: begin
                    if (scnt_q == '0) begin
                        sstate_q   <= S_CHECK;
                        sellando_q <= 1'b0;
                    end else begin
                        scnt_q <= scnt_q - SW'(1);
                    end
                end
                S_CHECK: begin
                    if (productook) begin
                        good_q   <= good_d;
                        lane_q   <= '0;
                        sstate_q <= S_IDLE;
                    end else if (!last_try) begin
                        retry_q    <= retry_q + 3'd1;
                        scnt_q     <= SW'(SEAL_CYCLES - 1);
                        sellando_q <= 1'b1;
                        sstate_q   <= S_SEAL;
                    end else begin
                        rej_q    <= rej_d;
                        lane_q   <= '0;
                        sstate_q <= S_IDLE;
                    end
                end
                default: begin
                    sstate_q   <= S_IDLE;
                    sellando_q <= 1'b0;
                    lane_q     <= '0;
                end
            endcase
        end
    end

    // Verdict pulses are Mealy: valid only during the single check cycle.
    assign LED          = chk && productook;
    assign reject       = chk && !productook && last_try;
    assign sellando     = sellando_q;
    assign seal_lane    = lane_q;
    assign good_count   = good_q;
    assign reject_count = rej_q;
    assign state_sealer = sstate_q;

endmodule

// File: tb/tb_fill_seal_line.sv
// Directed bench for fill_seal_line (N=2, F=8, S=4, R=2).
// A second instance with CNT_W=2 shares the stimulus for saturation.
module tb_fill_seal_line;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] startfill = 2'b00;
    logic       productook = 1'b0;

    logic [1:0] llenando;
    logic       sellando;
    logic [0:0] seal_lane;
    logic       LED;
    logic       reject;
    logic [7:0] good_count;
    logic [7:0] reject_count;
    logic [5:0] state_filler;
    logic [2:0] state_sealer;

    logic [1:0] llenando_b;
    logic       sellando_b;
    logic [0:0] seal_lane_b;
    logic       LED_b;
    logic       reject_b;
    logic [1:0] good_count_b;
    logic [1:0] reject_count_b;
    logic [5:0] state_filler_b;
    logic [2:0] state_sealer_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fill_seal_line dut (
        .clk(clk), .rst(rst), .startfill(startfill), .productook(productook),
        .llenando(llenando), .sellando(sellando), .seal_lane(seal_lane),
        .LED(LED), .reject(reject), .good_count(good_count),
        .reject_count(reject_count), .state_filler(state_filler),
        .state_sealer(state_sealer)
    );

    fill_seal_line #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .startfill(startfill), .productook(productook),
        .llenando(llenando_b), .sellando(sellando_b), .seal_lane(seal_lane_b),
        .LED(LED_b), .reject(reject_b), .good_count(good_count_b),
        .reject_count(reject_count_b), .state_filler(state_filler_b),
        .state_sealer(state_sealer_b)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        startfill = 2'b00;
        productook = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Present v so it is sampled at the next rising edge ("edge 0").
    task automatic launch(input logic [1:0] v);
        @(negedge clk);
        startfill = v;
        @(posedge clk);
        #1 startfill = 2'b00;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({llenando, sellando, seal_lane, LED, reject, good_count,
             reject_count, state_filler, state_sealer} !== 31'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got %b want 0",
                     {llenando, sellando, seal_lane, LED, reject, good_count,
                      reject_count, state_filler, state_sealer});
        end
        n_cmp++;
        if ({llenando_b, sellando_b, seal_lane_b, LED_b, reject_b, good_count_b,
             reject_count_b, state_filler_b, state_sealer_b} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_outputs_b got nonzero");
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        logic el, es, ed;
        do_reset();
        productook = 1'b1;
        launch(2'b01);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            el = (c <= 8);
            es = (c >= 10 && c <= 13);
            ed = (c == 14);
            n_cmp++;
            if ({llenando[0], sellando, LED} !== {el, es, ed}) begin
                n_bad++;
                $display("FAIL single c=%0d fill/seal/led got %b%b%b want %b%b%b",
                         c, llenando[0], sellando, LED, el, es, ed);
            end
            if (c == 9) begin
                n_cmp++;
                if (state_filler[2:0] !== 3'd2) begin
                    n_bad++;
                    $display("FAIL single_full got %0d want 2", state_filler[2:0]);
                end
            end
            if (c == 14) begin
                n_cmp++;
                if (state_sealer !== 3'd2) begin
                    n_bad++;
                    $display("FAIL single_check got %0d want 2", state_sealer);
                end
            end
        end
        n_cmp++;
        if (good_count !== 8'd1 || state_filler !== 6'd0) begin
            n_bad++;
            $display("FAIL single_end good=%0d lanes=%b want 1 000000",
                     good_count, state_filler);
        end
    endtask

    task automatic test_dual();
        logic [1:0] el;
        logic       es, ed, ln;
        do_reset();
        productook = 1'b1;
        for (int r = 0; r < 2; r++) begin
            launch(2'b11);
            for (int c = 1; c <= 21; c++) begin
                @(negedge clk);
                el = (c <= 8) ? 2'b11 : 2'b00;
                es = (c >= 10 && c <= 13) || (c >= 16 && c <= 19);
                ed = (c == 14) || (c == 20);
                ln = (c >= 16 && c <= 20);
                n_cmp++;
                if ({llenando, sellando, LED, seal_lane} !== {el, es, ed, ln}) begin
                    n_bad++;
                    $display("FAIL dual r=%0d c=%0d fill/seal/led/lane got %b %b%b%b want %b %b%b%b",
                             r, c, llenando, sellando, LED, seal_lane, el, es, ed, ln);
                end
            end
            n_cmp++;
            if (good_count !== 8'(2 * (r + 1)) || state_filler !== 6'd0) begin
                n_bad++;
                $display("FAIL dual_end r=%0d good=%0d lanes=%b want %0d 000000",
                         r, good_count, state_filler, 2 * (r + 1));
            end
        end
    endtask

    task automatic test_reject();
        logic es, rj;
        do_reset();
        productook = 1'b0;
        launch(2'b01);
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            es = (c >= 10 && c <= 23 && ((c - 10) % 5) != 4);
            rj = (c == 24);
            n_cmp++;
            if ({sellando, reject, LED} !== {es, rj, 1'b0}) begin
                n_bad++;
                $display("FAIL reject c=%0d seal/rej/led got %b%b%b want %b%b0",
                         c, sellando, reject, LED, es, rj);
            end
        end
        n_cmp++;
        if ({reject_count, good_count} !== {8'd1, 8'd0} ||
            state_filler !== 6'd0 || state_sealer !== 3'd0) begin
            n_bad++;
            $display("FAIL reject_end rej=%0d good=%0d lanes=%b seal=%0d want 1 0 0 0",
                     reject_count, good_count, state_filler, state_sealer);
        end
    endtask

    task automatic test_retry_pass();
        logic es, ed, rj;
        do_reset();
        productook = 1'b0;
        launch(2'b01);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            es = (c >= 10 && c <= 13) || (c >= 15 && c <= 18);
            ed = (c == 19);
            n_cmp++;
            if ({sellando, LED, reject} !== {es, ed, 1'b0}) begin
                n_bad++;
                $display("FAIL retry_pass c=%0d seal/led/rej got %b%b%b want %b%b0",
                         c, sellando, LED, reject, es, ed);
            end
            if (c == 15) productook = 1'b1;
        end
        n_cmp++;
        if ({good_count, reject_count} !== {8'd1, 8'd0} || state_filler !== 6'd0) begin
            n_bad++;
            $display("FAIL retry_pass_end good=%0d rej=%0d want 1 0",
                     good_count, reject_count);
        end
        // Full retry budget again: a stale retry would reject early.
        productook = 1'b0;
        launch(2'b01);
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            rj = (c == 24);
            n_cmp++;
            if (reject !== rj) begin
                n_bad++;
                $display("FAIL retry_clear c=%0d reject got %b want %b", c, reject, rj);
            end
        end
        n_cmp++;
        if ({good_count, reject_count} !== {8'd1, 8'd1}) begin
            n_bad++;
            $display("FAIL retry_clear_end good=%0d rej=%0d want 1 1",
                     good_count, reject_count);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        productook = 1'b1;
        for (int j = 0; j < 5; j++) begin
            launch(2'b01);
            repeat (15) @(negedge clk);
            n_cmp++;
            if (good_count !== 8'(j + 1) ||
                good_count_b !== 2'((j + 1 > 3) ? 3 : j + 1)) begin
                n_bad++;
                $display("FAIL saturate j=%0d good=%0d good_b=%0d want %0d %0d",
                         j, good_count, good_count_b, j + 1, (j + 1 > 3) ? 3 : j + 1);
            end
        end
    endtask

    task automatic test_reset_mid_seal();
        do_reset();
        productook = 1'b1;
        launch(2'b01);
        repeat (11) @(negedge clk);
        n_cmp++;
        if (sellando !== 1'b1) begin
            n_bad++;
            $display("FAIL midseal_pre sellando got %b want 1", sellando);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({llenando, sellando, seal_lane, LED, reject, good_count,
             reject_count, state_filler, state_sealer} !== 31'd0) begin
            n_bad++;
            $display("FAIL midseal_async got %b want 0",
                     {llenando, sellando, seal_lane, LED, reject, good_count,
                      reject_count, state_filler, state_sealer});
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if ({state_filler, state_sealer, good_count, reject_count, sellando} !== 26'd0) begin
            n_bad++;
            $display("FAIL midseal_after lanes=%b seal=%0d good=%0d rej=%0d want 0",
                     state_filler, state_sealer, good_count, reject_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual();
        test_reject();
        test_retry_pass();
        test_saturate();
        test_reset_mid_seal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
